// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
// Port-select encodings, priority-mode encodings and the response-pipeline record.
package mem_arb_pkg;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  localparam int PRIO_RR     = 0;
  localparam int PRIO_DFIRST = 1;

  typedef struct packed {
    logic  valid;
    port_e port;
    logic  oor;
  } rsp_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input arbiter: a sole requester wins outright; ties go to D in fixed-priority
// mode, otherwise to whichever port did not win last.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       mode,
  output logic [1:0] gnt
);

  always_comb begin
    // NOTE: give every output of a combinational block a default first so that no
    // path leaves it unassigned, which would infer a latch.
    gnt = 2'b00;
    if (req[PORT_I] && req[PORT_D]) begin
      if (mode || (last == PORT_I)) begin
        gnt[PORT_D] = 1'b1;
      end else begin
        gnt[PORT_I] = 1'b1;
      end
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read word memory between the fetch (I) and load/store (D) ports:
// one combinational grant per cycle, read data returned to the winner one cycle later.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 1024,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic              MODE_DFIRST = (PRIO_MODE == PRIO_DFIRST);
  localparam logic [ADDR_W:0]   DEPTH_LIM   = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              any_gnt;
  logic              in_range;
  logic [ADDR_W-1:0] sel_addr;
  port_e             win_port;
  port_e             last_winner;
  rsp_t              rsp_d;
  rsp_t              rsp_q;
  logic              err_q;
  logic [DATA_W-1:0] rsp_data;
  logic [DATA_W-1:0] i_hold_q;
  logic [DATA_W-1:0] d_hold_q;

  // Requests are masked while reset is held so every output, including the grants, reads 0.
  assign req[PORT_I] = i_req & rst_n;
  assign req[PORT_D] = d_req & rst_n;

  rr_arb2 u_arb (
    .req  (req),
    .last (last_winner),
    .mode (MODE_DFIRST),
    .gnt  (gnt)
  );

  assign i_gnt    = gnt[PORT_I];
  assign d_gnt    = gnt[PORT_D];
  assign any_gnt  = |gnt;
  assign win_port = gnt[PORT_D] ? PORT_D : PORT_I;

  always_comb begin
    sel_addr  = (win_port == PORT_D) ? d_addr : i_addr;
    in_range  = ({1'b0, sel_addr} < DEPTH_LIM);
    mem_en    = any_gnt && in_range;
    mem_we    = mem_en && (win_port == PORT_D) && d_we;
    mem_addr  = any_gnt ? sel_addr : '0;
    mem_wdata = gnt[PORT_D] ? d_wdata : '0;
  end

  // Out-of-range reads still get a response slot so the requester is never left waiting.
  always_comb begin
    rsp_d       = '0;
    rsp_d.valid = any_gnt && !((win_port == PORT_D) && d_we);
    rsp_d.port  = win_port;
    rsp_d.oor   = !in_range;
  end

  assign rsp_data = rsp_q.oor ? '0 : mem_rdata;
  assign i_rvalid = rsp_q.valid && (rsp_q.port == PORT_I);
  assign d_rvalid = rsp_q.valid && (rsp_q.port == PORT_D);
  assign i_rdata  = i_rvalid ? rsp_data : i_hold_q;
  assign d_rdata  = d_rvalid ? rsp_data : d_hold_q;
  assign err      = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_winner <= PORT_D;
      rsp_q       <= '0;
      err_q       <= 1'b0;
      i_hold_q    <= '0;
      d_hold_q    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // the pre-edge values, independent of statement order.
      if (any_gnt) begin
        last_winner <= win_port;
      end
      rsp_q <= rsp_d;
      err_q <= any_gnt && !in_range;
      if (i_rvalid) begin
        i_hold_q <= rsp_data;
      end
      if (d_rvalid) begin
        d_hold_q <= rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (round-robin, D-first, DEPTH=1000) each with
// its own memory; directed scenarios plus randomized traffic against a rule-level model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  logic [2:0]       i_req, i_gnt, i_rvalid, d_req, d_we, d_gnt, d_rvalid, err, mem_en, mem_we;
  logic [2:0][9:0]  i_addr, d_addr, mem_addr;
  logic [2:0][31:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;

  logic [31:0] env_mem [3][1024];
  logic [31:0] ref_mem [3][1024];
  logic        bd_en;
  int          bd_k;
  logic [9:0]  bd_addr;
  logic [31:0] bd_data;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W    (10),
      .DEPTH     ((g == 2) ? 1000 : 1024),
      .DATA_W    (32),
      .PRIO_MODE ((g == 1) ? 1 : 0)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req     (i_req[g]),
      .i_addr    (i_addr[g]),
      .i_gnt     (i_gnt[g]),
      .i_rvalid  (i_rvalid[g]),
      .i_rdata   (i_rdata[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_gnt     (d_gnt[g]),
      .d_rvalid  (d_rvalid[g]),
      .d_rdata   (d_rdata[g]),
      .err       (err[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g])
    );
  end

  // Synchronous-read memories, one per instance, plus a backdoor write port for preloading.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (mem_en[g]) begin
        if (mem_we[g]) env_mem[g][mem_addr[g]] <= mem_wdata[g];
        else           mem_rdata[g] <= env_mem[g][mem_addr[g]];
      end
    end
    if (bd_en) env_mem[bd_k][bd_addr] <= bd_data;
  end

  // Requesters must hold addr/we/wdata while a request waits ungranted.
  logic [2:0]       hold_i_mon, hold_d_mon;
  logic [2:0][9:0]  p_i_addr, p_d_addr;
  logic [2:0]       p_d_we;
  logic [2:0][31:0] p_d_wdata;
  initial begin
    hold_i_mon = '0;
    hold_d_mon = '0;
  end
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rst_n && hold_i_mon[g] && i_req[g]) begin
        checks++;
        if (i_addr[g] !== p_i_addr[g]) begin
          fails++;
          $display("FAIL protocol_hold_i dut%0d addr got=%0d held=%0d", g, i_addr[g], p_i_addr[g]);
        end
      end
      if (rst_n && hold_d_mon[g] && d_req[g]) begin
        checks++;
        if ({d_we[g], d_addr[g], d_wdata[g]} !== {p_d_we[g], p_d_addr[g], p_d_wdata[g]}) begin
          fails++;
          $display("FAIL protocol_hold_d dut%0d got=%h held=%h", g,
                   {d_we[g], d_addr[g], d_wdata[g]}, {p_d_we[g], p_d_addr[g], p_d_wdata[g]});
        end
      end
      hold_i_mon[g] = i_req[g] && !i_gnt[g];
      hold_d_mon[g] = d_req[g] && !d_gnt[g];
      p_i_addr[g]   = i_addr[g];
      p_d_addr[g]   = d_addr[g];
      p_d_we[g]     = d_we[g];
      p_d_wdata[g]  = d_wdata[g];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req = '0; d_req = '0; d_we = '0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic bd_write(input int k, input logic [9:0] a, input logic [31:0] v);
    bd_en = 1'b1; bd_k = k; bd_addr = a; bd_data = v;
    step();
    bd_en = 1'b0;
  endtask

  function automatic int depth_of(input int k);
    return (k == 2) ? 1000 : 1024;
  endfunction

  function automatic logic [9:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 10'(990 + $urandom_range(0, 33));
    return 10'($urandom_range(0, 15));
  endfunction

  task automatic test_reset();
    idle();
    bd_en = 1'b0;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if ({i_gnt[0], d_gnt[0], i_rvalid[0], d_rvalid[0], err[0], mem_en[0], mem_we[0]} !== 7'b0) begin
      fails++;
      $display("FAIL reset.ctrl got=%b exp=0000000",
               {i_gnt[0], d_gnt[0], i_rvalid[0], d_rvalid[0], err[0], mem_en[0], mem_we[0]});
    end
    checks++;
    if ({i_rdata[0], d_rdata[0], mem_addr[0], mem_wdata[0]} !== '0) begin
      fails++;
      $display("FAIL reset.data got=%h exp=0", {i_rdata[0], d_rdata[0], mem_addr[0], mem_wdata[0]});
    end
    step();
    i_req[0] = 1'b1; i_addr[0] = 10'd5;
    @(negedge clk);
    checks++;
    if ({i_gnt[0], mem_en[0]} !== 2'b11) begin
      fails++; $display("FAIL reset.pre_gnt got=%b exp=11", {i_gnt[0], mem_en[0]});
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({i_gnt[0], mem_en[0]} !== 2'b00) begin
      fails++; $display("FAIL reset.gnt_in_reset got=%b exp=00", {i_gnt[0], mem_en[0]});
    end
    step();
    i_req[0] = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({i_rvalid[0], d_rvalid[0], err[0], i_gnt[0], mem_en[0]} !== 5'b0 || i_rdata[0] !== 32'h0) begin
        fails++;
        $display("FAIL reset.after_release c=%0d ctrl=%b i_rdata=%h exp=0", c,
                 {i_rvalid[0], d_rvalid[0], err[0], i_gnt[0], mem_en[0]}, i_rdata[0]);
      end
      step();
    end
  endtask

  task automatic test_sole_read();
    bd_write(0, 10'd5, 32'h0000AF01);
    i_req[0] = 1'b1; i_addr[0] = 10'd5;
    @(negedge clk);
    checks++;
    if ({i_gnt[0], d_gnt[0], mem_en[0], mem_we[0]} !== 4'b1010 || mem_addr[0] !== 10'd5) begin
      fails++;
      $display("FAIL sole_read.issue gnt_i/gnt_d/en/we got=%b exp=1010 addr got=%0d exp=5",
               {i_gnt[0], d_gnt[0], mem_en[0], mem_we[0]}, mem_addr[0]);
    end
    step();
    i_req[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (i_rvalid[0] !== 1'b1 || i_rdata[0] !== 32'h0000AF01 || d_rvalid[0] !== 1'b0) begin
      fails++;
      $display("FAIL sole_read.resp i_rvalid=%b i_rdata=%h d_rvalid=%b exp 1 0000af01 0",
               i_rvalid[0], i_rdata[0], d_rvalid[0]);
    end
    step();
    @(negedge clk);
    checks++;
    if (i_rvalid[0] !== 1'b0 || i_rdata[0] !== 32'h0000AF01) begin
      fails++;
      $display("FAIL sole_read.hold i_rvalid=%b i_rdata=%h exp 0 0000af01", i_rvalid[0], i_rdata[0]);
    end
    step();
  endtask

  task automatic test_rr_contention();
    bd_write(0, 10'd10, 32'hA0A0_0010);
    bd_write(0, 10'd20, 32'hD0D0_0020);
    do_reset();
    i_req[0] = 1'b1; i_addr[0] = 10'd10;
    d_req[0] = 1'b1; d_addr[0] = 10'd20; d_we[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      logic ei, ed, eirv, edrv;
      if (c == 4) idle();
      ei   = (c < 4) && (c % 2 == 0);
      ed   = (c < 4) && (c % 2 == 1);
      eirv = (c >= 1) && ((c - 1) % 2 == 0);
      edrv = (c >= 1) && ((c - 1) % 2 == 1);
      @(negedge clk);
      checks++;
      if ({i_gnt[0], d_gnt[0]} !== {ei, ed}) begin
        fails++; $display("FAIL rr.gnt c=%0d got=%b exp=%b", c, {i_gnt[0], d_gnt[0]}, {ei, ed});
      end
      checks++;
      if ({i_rvalid[0], d_rvalid[0]} !== {eirv, edrv}) begin
        fails++; $display("FAIL rr.rvalid c=%0d got=%b exp=%b", c, {i_rvalid[0], d_rvalid[0]}, {eirv, edrv});
      end
      if (eirv) begin
        checks++;
        if (i_rdata[0] !== 32'hA0A0_0010) begin
          fails++; $display("FAIL rr.i_rdata c=%0d got=%h exp=a0a00010", c, i_rdata[0]);
        end
      end
      if (edrv) begin
        checks++;
        if (d_rdata[0] !== 32'hD0D0_0020) begin
          fails++; $display("FAIL rr.d_rdata c=%0d got=%h exp=d0d00020", c, d_rdata[0]);
        end
      end
      step();
    end
  endtask

  task automatic test_prio_dfirst();
    i_req[1] = 1'b1; i_addr[1] = 10'd7;
    d_req[1] = 1'b1; d_addr[1] = 10'd8; d_we[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      logic ei, ed;
      if (c == 3) d_req[1] = 1'b0;
      ei = (c == 3);
      ed = (c < 3);
      @(negedge clk);
      checks++;
      if ({i_gnt[1], d_gnt[1]} !== {ei, ed}) begin
        fails++; $display("FAIL prio.gnt c=%0d got=%b exp=%b", c, {i_gnt[1], d_gnt[1]}, {ei, ed});
      end
      step();
    end
    idle();
    step();
  endtask

  task automatic test_store_load();
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 10'd1023; d_wdata[0] = 32'h12345678;
    @(negedge clk);
    checks++;
    if ({d_gnt[0], i_gnt[0], mem_en[0], mem_we[0]} !== 4'b1011 || mem_addr[0] !== 10'd1023 ||
        mem_wdata[0] !== 32'h12345678) begin
      fails++;
      $display("FAIL store.issue ctrl=%b exp=1011 addr=%0d exp=1023 wdata=%h exp=12345678",
               {d_gnt[0], i_gnt[0], mem_en[0], mem_we[0]}, mem_addr[0], mem_wdata[0]);
    end
    step();
    d_we[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (d_rvalid[0] !== 1'b0 || d_gnt[0] !== 1'b1 || mem_we[0] !== 1'b0 || err[0] !== 1'b0) begin
      fails++;
      $display("FAIL store.no_rvalid d_rvalid=%b d_gnt=%b mem_we=%b err=%b exp 0 1 0 0",
               d_rvalid[0], d_gnt[0], mem_we[0], err[0]);
    end
    step();
    idle();
    @(negedge clk);
    checks++;
    if (d_rvalid[0] !== 1'b1 || d_rdata[0] !== 32'h12345678 || err[0] !== 1'b0) begin
      fails++;
      $display("FAIL load.resp d_rvalid=%b d_rdata=%h err=%b exp 1 12345678 0", d_rvalid[0], d_rdata[0], err[0]);
    end
    step();
  endtask

  task automatic test_out_of_range();
    bd_write(2, 10'd3, 32'h55AA_33CC);
    d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 10'd3;
    step();
    d_addr[2] = 10'd1010;
    @(negedge clk);
    checks++;
    if ({d_gnt[2], mem_en[2], d_rvalid[2], err[2]} !== 4'b1010 || d_rdata[2] !== 32'h55AA_33CC) begin
      fails++;
      $display("FAIL oor.load_issue gnt/en/rvalid/err=%b exp=1010 d_rdata=%h exp=55aa33cc",
               {d_gnt[2], mem_en[2], d_rvalid[2], err[2]}, d_rdata[2]);
    end
    step();
    d_we[2] = 1'b1; d_addr[2] = 10'd1000; d_wdata[2] = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({err[2], d_rvalid[2], d_gnt[2], mem_en[2]} !== 4'b1110 || d_rdata[2] !== 32'h0) begin
      fails++;
      $display("FAIL oor.load_resp err/rvalid/gnt/en=%b exp=1110 d_rdata=%h exp=0",
               {err[2], d_rvalid[2], d_gnt[2], mem_en[2]}, d_rdata[2]);
    end
    step();
    idle();
    i_req[2] = 1'b1; i_addr[2] = 10'd999;
    @(negedge clk);
    checks++;
    if ({err[2], d_rvalid[2], i_gnt[2], mem_en[2]} !== 4'b1011 || d_rdata[2] !== 32'h0) begin
      fails++;
      $display("FAIL oor.store_resp err/rvalid/gnt/en=%b exp=1011 d_rdata=%h exp=0",
               {err[2], d_rvalid[2], i_gnt[2], mem_en[2]}, d_rdata[2]);
    end
    step();
    idle();
    @(negedge clk);
    checks++;
    if ({err[2], i_rvalid[2]} !== 2'b01) begin
      fails++; $display("FAIL oor.edge_read err/i_rvalid=%b exp=01", {err[2], i_rvalid[2]});
    end
    step();
  endtask

  // Randomized traffic on instance k, checked cycle by cycle against the arbitration rules.
  task automatic test_random(input int k, input int ncyc);
    logic        last_d, pv, pport_d, poor, perr, gi_prev, gd_prev;
    logic        ir, dr, ei, ed, inr, e_en, e_we, e_irv, e_drv;
    logic [9:0]  wa;
    logic [31:0] pdata, hold_i, hold_d, rv_data, e_ird, e_drd;
    do_reset();
    for (int a = 0; a < 1024; a++) begin
      if (a < 16 || a >= 990) begin
        logic [31:0] v;
        v = $urandom;
        ref_mem[k][a] = v;
        bd_write(k, 10'(a), v);
      end
    end
    last_d = 1'b1; pv = 1'b0; pport_d = 1'b0; poor = 1'b0; perr = 1'b0; pdata = '0;
    hold_i = '0; hold_d = '0; gi_prev = 1'b0; gd_prev = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (gi_prev || !i_req[k]) begin
        i_req[k] = ($urandom_range(0, 9) < 6);
        if (i_req[k]) i_addr[k] = rand_addr();
      end else if ($urandom_range(0, 19) == 0) begin
        i_req[k] = 1'b0;
      end
      if (gd_prev || !d_req[k]) begin
        d_req[k] = ($urandom_range(0, 9) < 6);
        if (d_req[k]) begin
          d_we[k] = $urandom_range(0, 1) == 1;
          d_addr[k] = rand_addr();
          d_wdata[k] = $urandom;
        end
      end else if ($urandom_range(0, 19) == 0) begin
        d_req[k] = 1'b0;
      end
      @(negedge clk);
      ir    = i_req[k];
      dr    = d_req[k];
      ei    = ir && (!dr || ((k != 1) && last_d));
      ed    = dr && !ei;
      wa    = ed ? d_addr[k] : i_addr[k];
      inr   = int'(wa) < depth_of(k);
      e_en  = (ei || ed) && inr;
      e_we  = ed && d_we[k];
      e_irv = pv && !pport_d;
      e_drv = pv && pport_d;
      rv_data = poor ? 32'h0 : pdata;
      e_ird = e_irv ? rv_data : hold_i;
      e_drd = e_drv ? rv_data : hold_d;
      checks++;
      if ({i_gnt[k], d_gnt[k], mem_en[k]} !== {ei, ed, e_en}) begin
        fails++;
        $display("FAIL rand%0d.issue c=%0d gnt_i/gnt_d/en got=%b exp=%b", k, c,
                 {i_gnt[k], d_gnt[k], mem_en[k]}, {ei, ed, e_en});
      end
      if (e_en) begin
        checks++;
        if (mem_we[k] !== e_we || mem_addr[k] !== wa || (e_we && mem_wdata[k] !== d_wdata[k])) begin
          fails++;
          $display("FAIL rand%0d.mem c=%0d we=%b addr=%0d wdata=%h exp we=%b addr=%0d wdata=%h", k, c,
                   mem_we[k], mem_addr[k], mem_wdata[k], e_we, wa, d_wdata[k]);
        end
      end
      checks++;
      if ({i_rvalid[k], d_rvalid[k], err[k]} !== {e_irv, e_drv, perr}) begin
        fails++;
        $display("FAIL rand%0d.resp c=%0d rv_i/rv_d/err got=%b exp=%b", k, c,
                 {i_rvalid[k], d_rvalid[k], err[k]}, {e_irv, e_drv, perr});
      end
      checks++;
      if (i_rdata[k] !== e_ird || d_rdata[k] !== e_drd) begin
        fails++;
        $display("FAIL rand%0d.rdata c=%0d i=%h d=%h exp i=%h d=%h", k, c, i_rdata[k], d_rdata[k], e_ird, e_drd);
      end
      hold_i = e_ird;
      hold_d = e_drd;
      if (ei || ed) last_d = ed;
      pv      = ei || (ed && !d_we[k]);
      pport_d = ed;
      poor    = !inr;
      perr    = (ei || ed) && !inr;
      pdata   = ref_mem[k][wa];
      if (e_en && e_we) ref_mem[k][wa] = d_wdata[k];
      gi_prev = ei;
      gd_prev = ed;
      step();
    end
    idle();
    step();
  endtask

  initial begin
    bd_en = 1'b0; bd_k = 0; bd_addr = '0; bd_data = '0;
    idle();
    rst_n = 1'b0;
    test_reset();
    test_sole_read();
    test_rr_contention();
    test_prio_dfirst();
    test_store_load();
    test_out_of_range();
    test_random(0, 400);
    test_random(1, 250);
    test_random(2, 300);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
